pc_sequencer: RTL and testbench

Parametrised program-counter unit replacing the fixed 8-bit jump/increment counter in the CPU fetch stage. It holds the fetch address, advances it by a fixed step each cycle, supports absolute and PC-relative jumps, and provides a hardware call/return stack. It also drives an ARM-style R15 read value (PC plus pipeline offset) to the register file. It sits between the control unit, which drives the jump, call, return and stall controls, and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter with sequential stepping, absolute and
//   PC-relative jumps, and a hardware call/return stack.
//
// Parameters
//   ADDR_W      width of the PC and all address ports
//   STEP        PC increment per sequential fetch
//   STACK_DEPTH number of return-stack entries (>= 1)
//   RESET_ADDR  PC value held while reset is asserted
//   R15_OFFSET  R15 read value is PC + R15_OFFSET*STEP
//
// Ports
//   clk_in          clock, all state updates on the rising edge
//   rst_in          asynchronous active-high reset
//   stall_in        hold PC, stack and error flag
//   jmp_en_in       take a jump this cycle
//   jmp_rel_in      1: addr_to_jmp_in is a signed offset from the PC
//   addr_to_jmp_in  jump target or signed offset
//   call_in         push return address (PC+STEP), then jump
//   ret_in          pop return address into the PC
//   PC_out          current fetch address (registered)
//   R15_out         PC_out + R15_OFFSET*STEP (combinational)
//   stack_full_out  stack holds STACK_DEPTH entries
//   stack_empty_out stack holds no entries
//   stack_err_out   sticky overflow/underflow flag, cleared by reset only
//
// Control priority per cycle: stall > ret > call > jump > increment.

module pc_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned R15_OFFSET  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              jmp_en_in,
  input  logic              jmp_rel_in,
  input  logic [ADDR_W-1:0] addr_to_jmp_in,
  input  logic              call_in,
  input  logic              ret_in,
  output logic [ADDR_W-1:0] PC_out,
  output logic [ADDR_W-1:0] R15_out,
  output logic              stack_full_out,
  output logic              stack_empty_out,
  output logic              stack_err_out
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  // Entry index width; a one-entry stack still needs a 1-bit index.
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] C_STEP      = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] C_RESET     = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] C_R15_DELTA = ADDR_W'(R15_OFFSET * STEP);
  localparam logic [PTR_W-1:0]  C_DEPTH     = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0]  C_ONE       = PTR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_err;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_err_nxt;
  logic              w_push;

  assign w_pc_inc = r_pc + C_STEP;
  // Same-width modular add equals adding the sign-extended offset.
  assign w_target = jmp_rel_in ? (r_pc + addr_to_jmp_in) : addr_to_jmp_in;
  assign w_full   = (r_ptr == C_DEPTH);
  assign w_empty  = (r_ptr == '0);

  // Pointer counts entries, so it addresses the next free slot; the top
  // entry sits one below it. Only used when the stack is non-empty/non-full.
  assign w_push_idx = IDX_W'(r_ptr);
  assign w_top_idx  = IDX_W'(r_ptr - C_ONE);

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_ptr_nxt = r_ptr;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (stall_in) begin
      w_pc_nxt = r_pc;
    end else if (ret_in) begin
      if (!w_empty) begin
        w_pc_nxt  = r_stack[w_top_idx];
        w_ptr_nxt = r_ptr - C_ONE;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (call_in) begin
      w_pc_nxt = w_target;
      if (!w_full) begin
        w_push    = 1'b1;
        w_ptr_nxt = r_ptr + C_ONE;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (jmp_en_in) begin
      w_pc_nxt = w_target;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pc  <= C_RESET;
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_ptr <= w_ptr_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Stack storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign PC_out          = r_pc;
  assign R15_out         = r_pc + C_R15_DELTA;
  assign stack_full_out  = w_full;
  assign stack_empty_out = w_empty;
  assign stack_err_out   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed scenarios followed by random control traffic for pc_sequencer
//   (default parameters), compared against a queue-based reference model.

module tb_pc_sequencer;

  localparam int AW    = 8;
  localparam int MOD   = 256;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          stall_in = 1'b0;
  logic          jmp_en_in = 1'b0;
  logic          jmp_rel_in = 1'b0;
  logic [AW-1:0] addr_to_jmp_in = '0;
  logic          call_in = 1'b0;
  logic          ret_in = 1'b0;
  logic [AW-1:0] PC_out;
  logic [AW-1:0] R15_out;
  logic          stack_full_out;
  logic          stack_empty_out;
  logic          stack_err_out;

  pc_sequencer #(
    .ADDR_W(8), .STEP(1), .STACK_DEPTH(4), .RESET_ADDR(0), .R15_OFFSET(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .jmp_en_in(jmp_en_in), .jmp_rel_in(jmp_rel_in),
    .addr_to_jmp_in(addr_to_jmp_in), .call_in(call_in), .ret_in(ret_in),
    .PC_out(PC_out), .R15_out(R15_out), .stack_full_out(stack_full_out),
    .stack_empty_out(stack_empty_out), .stack_err_out(stack_err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pc  = 0;
  int m_err = 0;
  int m_stk[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(PC_out),          32'(m_pc));
    check({tag, ".r15"},   32'(R15_out),         32'((m_pc + 2) % MOD));
    check({tag, ".full"},  32'(stack_full_out),  32'(m_stk.size() == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty_out), 32'(m_stk.size() == 0));
    check({tag, ".err"},   32'(stack_err_out),   32'(m_err));
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_err = 0;
    m_stk.delete();
  endtask

  // One clock cycle: drive controls, advance the model, sample after the edge.
  task automatic step(input string tag, input bit s, input bit r, input bit c,
                      input bit j, input bit rel, input logic [AW-1:0] a);
    int tgt;
    stall_in = s; ret_in = r; call_in = c; jmp_en_in = j;
    jmp_rel_in = rel; addr_to_jmp_in = a;
    tgt = rel ? ((m_pc + int'($signed(a)) + MOD) % MOD) : int'(a);
    if (s) begin
      // hold everything
    end else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) % MOD; m_err = 1; end
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MOD);
      else m_err = 1;
      m_pc = tgt;
    end else if (j) begin
      m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    #2 rst_in = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic inc(input string tag);
    step(tag, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    // Power-on reset
    #2;
    model_reset();
    check_all("por");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Increment from reset
    inc("inc1"); inc("inc2"); inc("inc3");
    check("inc3.pc_const", 32'(PC_out), 32'd3);
    check("inc3.r15_const", 32'(R15_out), 32'd5);

    pulse_reset("rst_mid");
    check("rst_mid.r15_const", 32'(R15_out), 32'd2);

    // Wrap
    step("wrap_jmp", 0, 0, 0, 1, 0, 8'hFE);
    inc("wrap1");
    inc("wrap2");
    check("wrap.pc_const", 32'(PC_out), 32'h00);
    check("wrap.err_const", 32'(stack_err_out), 32'd0);

    // Relative jump, then the same while stalled
    step("rel_set", 0, 0, 0, 1, 0, 8'h10);
    step("rel_back", 0, 0, 0, 1, 1, 8'hF8);
    check("rel_back.pc_const", 32'(PC_out), 32'h08);
    step("rel_set2", 0, 0, 0, 1, 0, 8'h10);
    step("rel_stall", 1, 0, 0, 1, 1, 8'hF8);
    check("rel_stall.pc_const", 32'(PC_out), 32'h10);

    // Call / return
    step("cr_set", 0, 0, 0, 1, 0, 8'h20);
    step("cr_call", 0, 0, 1, 0, 0, 8'h40);
    inc("cr_inc1"); inc("cr_inc2");
    step("cr_ret", 0, 1, 0, 0, 0, '0);
    check("cr_ret.pc_const", 32'(PC_out), 32'h21);
    check("cr_ret.empty_const", 32'(stack_empty_out), 32'd1);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) step($sformatf("ovf_call%0d", i), 0, 0, 1, 0, 0, 8'h80);
    check("ovf.err_const", 32'(stack_err_out), 32'd1);
    for (int i = 0; i < 5; i++) step($sformatf("unf_ret%0d", i), 0, 1, 0, 0, 0, '0);
    check("unf.pc_const", 32'(PC_out), 32'h23);

    // Priority: pop beats call and jump
    pulse_reset("prio_rst");
    step("prio_call", 0, 0, 1, 0, 0, 8'h50);
    step("prio_all", 0, 1, 1, 1, 0, 8'h90);
    check("prio_all.pc_const", 32'(PC_out), 32'h01);

    // Reset with two stacked entries, err set, and call held high
    step("mid_unf", 0, 1, 0, 0, 0, '0);
    step("mid_call1", 0, 0, 1, 0, 1, 8'h04);
    step("mid_call2", 0, 0, 1, 0, 1, 8'h04);
    stall_in = 0; ret_in = 0; jmp_en_in = 0; call_in = 1;
    pulse_reset("mid_rst");

    // Call then immediate return
    step("cr2_call", 0, 0, 1, 0, 1, 8'h30);
    step("cr2_ret", 0, 1, 0, 0, 0, '0);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)),
             AW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
